io_bus_arbiter: RTL and testbench
=================================

IO_BUS_ARBITER -- requirements
Module: io_bus_arbiter

Interface
REQ-001 SHALL have parameter BITS, default 32, meaning address/data bus width.
REQ-002 SHALL have parameter IO_BASE, default 32'hFFFF0000, meaning the lowest address of the memory-mapped IO window.
REQ-003 SHALL have ports CLK input 1 (the only clock) and RESET_N input 1 (asynchronous, active-low reset).
REQ-004 SHALL have ports REQ0 and REQ1, each input 1, meaning the requester 0 (CPU) and requester 1 (secondary master) transaction request.
REQ-005 SHALL have ports WE0 and WE1, each input 1, meaning the per-requester write (1) or read (0) select.
REQ-006 SHALL have ports ADDR0 and ADDR1, each input BITS, meaning the per-requester address.
REQ-007 SHALL have ports WDATA0 and WDATA1, each input BITS, meaning the per-requester write data.
REQ-008 SHALL have ports RDATA0 and RDATA1, each output BITS, meaning the per-requester read data, registered.
REQ-009 SHALL have ports ACK0 and ACK1, each output 1, meaning a one-cycle completion pulse.
REQ-010 SHALL have ports ERR0 and ERR1, each output 1, meaning error qualifier, valid only with the matching ACK.
REQ-011 SHALL have ports ADDRBUS output BITS, WE output 1 and DATABUS inout BITS, meaning the shared device bus.

Function
REQ-012 SHALL implement FSM states IDLE, BUS; IDLE->BUS when an eligible REQ is present, BUS->IDLE unconditionally after one cycle.
REQ-013 In IDLE, a requester is eligible only if its REQ=1 and its ACK=0 in the same cycle; this prevents re-granting a request that is being acknowledged.
REQ-014 Two eligible requesters SHALL be resolved round-robin: grant goes to the one not granted last; after reset requester 0 has priority.
REQ-015 On the IDLE->BUS edge, the arbiter SHALL latch the granted ADDR, WE and WDATA; later requester changes SHALL not affect the bus cycle.
REQ-016 In BUS, the arbiter SHALL drive ADDRBUS=latched address and WE=latched WE.
REQ-017 In BUS, DATABUS SHALL be driven with latched WDATA if writing, else released to Z.
REQ-018 Outside BUS, the arbiter SHALL drive ADDRBUS=0 and WE=0 and SHALL release DATABUS to Z.
REQ-019 On the BUS->IDLE edge, the arbiter SHALL set the granted ACK=1 for exactly one cycle; on reads it SHALL capture DATABUS into that RDATA.
REQ-020 RDATA SHALL hold its value until the next read completion for that requester; a write SHALL leave RDATA unchanged.
REQ-021 Latency SHALL be: REQ high before edge N -> bus cycle N..N+1 -> ACK high in cycle after edge N+1, i.e. two edges.
REQ-022 Back-to-back operation: the other requester may be granted in the ACK cycle, so the bus stays occupied in alternating cycles with no dead cycle beyond IDLE.
REQ-023 A requester SHALL hold REQ, ADDR, WE and WDATA until it sees ACK; if REQ is still high in the cycle after ACK, that is a new transaction.

Reset
REQ-024 RESET_N low SHALL asynchronously force: state IDLE, ACK0/1=0, ERR0/1=0, RDATA0/1=0, last-grant=1 (so requester 0 wins next), ADDRBUS=0, WE=0, DATABUS=Z.
REQ-025 Reset during BUS SHALL abort the cycle: no ACK SHALL be issued, and the requester SHALL re-issue after reset.

Configuration
REQ-026 Macro IO_BUS_ARBITER_RANGECHK_EN defined: a granted address below IO_BASE SHALL skip BUS, and ACK+ERR=1 SHALL pulse on the next edge, with the bus idle and RDATA unchanged.
REQ-027 Macro absent: no range check, ERR0/1 tied 0, and every grant SHALL run a BUS cycle.

Structure
REQ-028 Shared package io_pkg SHALL hold IO_BASE default, the device base constants (LED at 32'hFFFF0100) and the FSM state typedef.
REQ-029 A sub-module rr_pick2 SHALL provide the combinational two-way round-robin selection (inputs eligible[1:0], last; outputs grant, valid).

Verification
REQ-030 Write at reset: REQ0=1, WE0=1, ADDR0=FFFF0100, WDATA0=000000A5 -> one BUS cycle with DATABUS=000000A5, WE=1, then ACK0 one cycle later, so the LED device reads A5.
REQ-031 Read: REQ1=1, WE1=0, ADDR1=FFFF0100 with the LED holding A5 -> ACK1 two edges later and RDATA1=000000A5.
REQ-032 Contention: REQ0 and REQ1 high together and held -> grants alternate 0,1,0,1, with ACK0/ACK1 pulses never overlapping and no requester granted twice in a row.
REQ-033 Reset mid-BUS: assert RESET_N=0 in the BUS cycle -> ADDRBUS=0 and DATABUS=Z immediately, no ACK, and requester 0 wins first after release.
REQ-034 With the macro defined: REQ0 with ADDR0=00001000 -> ACK0=ERR0=1 one edge after grant, no BUS cycle, RDATA0 unchanged; without the macro, the same stimulus gives a normal BUS cycle with ERR0=0.

Source files
------------

// File: rtl/io_pkg.sv
// Shared constants and FSM state type for the IO bus arbiter and its devices.
package io_pkg;

    localparam logic [31:0] IO_BASE_DEFAULT = 32'hFFFF_0000;
    localparam logic [31:0] LED_BASE        = 32'hFFFF_0100;

    typedef enum logic {
        IDLE = 1'b0,
        BUS  = 1'b1
    } arb_state_t;

endpackage

// File: rtl/rr_pick2.sv
// Combinational two-way round-robin picker: on contention the requester
// that was not granted last wins.
module rr_pick2 (
    input  logic [1:0] eligible,
    input  logic       last,
    output logic       grant,
    output logic       valid
);

    // Pick the single eligible requester, or alternate when both are eligible.
    always_comb begin
        grant = 1'b0;
        valid = |eligible;
        case (eligible)
            2'b01:   grant = 1'b0;
            2'b10:   grant = 1'b1;
            2'b11:   grant = ~last;
            default: grant = 1'b0;
        endcase
    end

endmodule

// File: rtl/io_bus_arbiter.sv
// Two-master arbiter for a shared memory-mapped IO bus with one-cycle bus phases.
// Optional IO_BUS_ARBITER_RANGECHK_EN rejects grants below IO_BASE with ACK+ERR.
module io_bus_arbiter
    import io_pkg::*;
#(
    parameter int              BITS    = 32,
    parameter logic [BITS-1:0] IO_BASE = BITS'(IO_BASE_DEFAULT)
) (
    input  logic            CLK,
    input  logic            RESET_N,
    input  logic            REQ0,
    input  logic            REQ1,
    input  logic            WE0,
    input  logic            WE1,
    input  logic [BITS-1:0] ADDR0,
    input  logic [BITS-1:0] ADDR1,
    input  logic [BITS-1:0] WDATA0,
    input  logic [BITS-1:0] WDATA1,
    output logic [BITS-1:0] RDATA0,
    output logic [BITS-1:0] RDATA1,
    output logic            ACK0,
    output logic            ACK1,
    output logic            ERR0,
    output logic            ERR1,
    output logic [BITS-1:0] ADDRBUS,
    output logic            WE,
    inout  wire  [BITS-1:0] DATABUS
);

    arb_state_t      state_r;
    arb_state_t      state_nx_s;
    logic [1:0]      ack_r;
    logic            last_r;
    logic            gnt_r;
    logic [BITS-1:0] rdata0_r;
    logic [BITS-1:0] rdata1_r;
    logic [BITS-1:0] bus_addr_r;
    logic            bus_we_r;
    logic [BITS-1:0] bus_wdata_r;

    logic [1:0]      elig_s;
    logic            pick_s;
    logic            valid_s;
    logic [BITS-1:0] sel_addr_s;
    logic            sel_we_s;
    logic [BITS-1:0] sel_wdata_s;
    logic            range_err_s;

    // A requester whose ACK is showing this cycle must not be granted again.
    assign elig_s = {REQ1 & ~ack_r[1], REQ0 & ~ack_r[0]};

    rr_pick2 u_pick (
        .eligible (elig_s),
        .last     (last_r),
        .grant    (pick_s),
        .valid    (valid_s)
    );

    // Mux the winning requester's transaction onto the latch inputs.
    always_comb begin
        sel_addr_s  = ADDR0;
        sel_we_s    = WE0;
        sel_wdata_s = WDATA0;
        if (pick_s) begin
            sel_addr_s  = ADDR1;
            sel_we_s    = WE1;
            sel_wdata_s = WDATA1;
        end else begin
            sel_addr_s  = ADDR0;
            sel_we_s    = WE0;
            sel_wdata_s = WDATA0;
        end
    end

`ifdef IO_BUS_ARBITER_RANGECHK_EN
    logic [1:0] err_r;

    assign range_err_s = (sel_addr_s < IO_BASE);
    assign ERR0        = err_r[0];
    assign ERR1        = err_r[1];
`else
    assign range_err_s = 1'b0;
    assign ERR0        = 1'b0;
    assign ERR1        = 1'b0;
`endif

    // FSM state register.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nx_s;
        end
    end

    // Next state: a clean grant opens a bus phase, which always lasts one cycle.
    always_comb begin
        state_nx_s = state_r;
        case (state_r)
            IDLE: begin
                if (valid_s && !range_err_s) begin
                    state_nx_s = BUS;
                end else begin
                    state_nx_s = IDLE;
                end
            end
            BUS:     state_nx_s = IDLE;
            default: state_nx_s = IDLE;
        endcase
    end

    // Grant latching, bus drive registers, completion pulses and read capture.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            ack_r       <= 2'b00;
            last_r      <= 1'b1;
            gnt_r       <= 1'b0;
            rdata0_r    <= {BITS{1'b0}};
            rdata1_r    <= {BITS{1'b0}};
            bus_addr_r  <= {BITS{1'b0}};
            bus_we_r    <= 1'b0;
            bus_wdata_r <= {BITS{1'b0}};
`ifdef IO_BUS_ARBITER_RANGECHK_EN
            err_r       <= 2'b00;
`endif
        end else begin
            ack_r <= 2'b00;
`ifdef IO_BUS_ARBITER_RANGECHK_EN
            err_r <= 2'b00;
`endif
            case (state_r)
                IDLE: begin
                    if (valid_s) begin
                        last_r <= pick_s;
                        gnt_r  <= pick_s;
                        if (range_err_s) begin
                            ack_r[pick_s] <= 1'b1;
`ifdef IO_BUS_ARBITER_RANGECHK_EN
                            err_r[pick_s] <= 1'b1;
`endif
                        end else begin
                            bus_addr_r  <= sel_addr_s;
                            bus_we_r    <= sel_we_s;
                            bus_wdata_r <= sel_wdata_s;
                        end
                    end else begin
                        last_r <= last_r;
                    end
                end
                BUS: begin
                    ack_r[gnt_r] <= 1'b1;
                    if (!bus_we_r) begin
                        if (gnt_r) begin
                            rdata1_r <= DATABUS;
                        end else begin
                            rdata0_r <= DATABUS;
                        end
                    end else begin
                        rdata0_r <= rdata0_r;
                    end
                    bus_addr_r  <= {BITS{1'b0}};
                    bus_we_r    <= 1'b0;
                    bus_wdata_r <= {BITS{1'b0}};
                end
                default: begin
                    bus_addr_r <= {BITS{1'b0}};
                    bus_we_r   <= 1'b0;
                end
            endcase
        end
    end

    assign ACK0    = ack_r[0];
    assign ACK1    = ack_r[1];
    assign RDATA0  = rdata0_r;
    assign RDATA1  = rdata1_r;
    assign ADDRBUS = bus_addr_r;
    assign WE      = bus_we_r;
    assign DATABUS = bus_we_r ? bus_wdata_r : {BITS{1'bz}};

endmodule

// File: tb/tb_io_bus_arbiter.sv
// Scoreboard bench for io_bus_arbiter with an LED register and a pattern device
// on the shared bus; honours IO_BUS_ARBITER_RANGECHK_EN for the range test.
module tb_io_bus_arbiter;
    import io_pkg::*;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        logic        err;
        logic        bus;
    } exp_t;

    logic        CLK = 1'b0;
    logic        RESET_N = 1'b0;
    logic        REQ0 = 1'b0, REQ1 = 1'b0, WE0 = 1'b0, WE1 = 1'b0;
    logic [31:0] ADDR0 = 32'h0, ADDR1 = 32'h0, WDATA0 = 32'h0, WDATA1 = 32'h0;
    logic [31:0] RDATA0, RDATA1, ADDRBUS;
    logic        ACK0, ACK1, ERR0, ERR1, WE;
    wire  [31:0] DATABUS;

    int          checks = 0;
    int          failures = 0;
    exp_t        q0[$];
    exp_t        q1[$];
    int          ack_order[$];
    int          bus_cycles = 0;
    int          bus_base = 0;
    logic [31:0] seen_addr = 32'h0, seen_data = 32'h0;
    logic        seen_we = 1'b0;
    logic        prev_ack0 = 1'b0, prev_ack1 = 1'b0;
    logic [31:0] shadow0 = 32'h0, shadow1 = 32'h0;
    logic [31:0] led_r = 32'h0;
    logic [31:0] zv = 32'hzzzz_zzzz;

    io_bus_arbiter #(.BITS(32)) u_dut (
        .CLK(CLK), .RESET_N(RESET_N),
        .REQ0(REQ0), .REQ1(REQ1), .WE0(WE0), .WE1(WE1),
        .ADDR0(ADDR0), .ADDR1(ADDR1), .WDATA0(WDATA0), .WDATA1(WDATA1),
        .RDATA0(RDATA0), .RDATA1(RDATA1), .ACK0(ACK0), .ACK1(ACK1),
        .ERR0(ERR0), .ERR1(ERR1), .ADDRBUS(ADDRBUS), .WE(WE), .DATABUS(DATABUS)
    );

    always #5 CLK = ~CLK;

    // Bus devices: LED register at LED_BASE, every other address reads addr^5A5A5A5A.
    always @(posedge CLK) begin
        if (WE && ADDRBUS == LED_BASE) led_r <= DATABUS;
    end
    assign DATABUS = (!WE && ADDRBUS != 32'h0) ?
                     ((ADDRBUS == LED_BASE) ? led_r : (ADDRBUS ^ 32'h5A5A_5A5A)) : 32'hzzzz_zzzz;

    task automatic check_val(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    task automatic score(input int r);
        exp_t        e;
        logic [31:0] rd;
        logic        er;
        rd = (r == 1) ? RDATA1 : RDATA0;
        er = (r == 1) ? ERR1 : ERR0;
        ack_order.push_back(r);
        if ((r == 0 && q0.size() == 0) || (r == 1 && q1.size() == 0)) begin
            check_val($sformatf("ack%0d_unexpected", r), 64'd1, 64'd0);
            return;
        end
        e = (r == 1) ? q1.pop_front() : q0.pop_front();
        if (e.we) check_val($sformatf("rdata%0d_hold", r), rd, (r == 1) ? shadow1 : shadow0);
        else      check_val($sformatf("rdata%0d", r), rd, e.rdata);
        if (!e.we && !e.err) begin
            if (r == 1) shadow1 = e.rdata;
            else        shadow0 = e.rdata;
        end
        check_val($sformatf("err%0d", r), er, e.err);
        check_val("bus_cycles", bus_cycles - bus_base, e.bus ? 1 : 0);
        bus_base = bus_cycles;
        if (e.bus) begin
            check_val("bus_addr", seen_addr, e.addr);
            check_val("bus_we", seen_we, e.we);
            check_val("bus_data", seen_data, e.we ? e.wdata : e.rdata);
        end
    endtask

    // Output monitor sampled on the falling edge.
    initial begin
        forever begin
            @(negedge CLK);
            if (RESET_N) begin
                if (ADDRBUS != 32'h0) begin
                    seen_addr = ADDRBUS;
                    seen_we   = WE;
                    seen_data = DATABUS;
                    bus_cycles++;
                end
                if (ACK0 || ACK1) check_val("ack_exclusive", ACK0 & ACK1, 1'b0);
                if (ACK0) begin
                    check_val("ack0_pulse", prev_ack0, 1'b0);
                    score(0);
                end
                if (ACK1) begin
                    check_val("ack1_pulse", prev_ack1, 1'b0);
                    score(1);
                end
            end
            prev_ack0 = ACK0;
            prev_ack1 = ACK1;
        end
    end

    // Issue one transaction, leave REQ high, and return at the negedge showing ACK.
    task automatic run_txn(input int r, input logic we, input logic [31:0] addr,
                           input logic [31:0] wdata, input logic [31:0] rdata,
                           input int lat_exp, input logic err, input logic bus);
        exp_t e;
        int   n;
        logic acked;
        e.we = we; e.addr = addr; e.wdata = wdata; e.rdata = rdata; e.err = err; e.bus = bus;
        if (r == 1) begin
            q1.push_back(e);
            WE1 = we; ADDR1 = addr; WDATA1 = wdata; REQ1 = 1'b1;
        end else begin
            q0.push_back(e);
            WE0 = we; ADDR0 = addr; WDATA0 = wdata; REQ0 = 1'b1;
        end
        n = 0;
        do begin
            @(posedge CLK);
            n++;
            @(negedge CLK);
            acked = (r == 1) ? ACK1 : ACK0;
        end while (!acked && n < 50);
        if (!acked) check_val($sformatf("ack%0d_timeout", r), 64'd0, 64'd1);
        if (lat_exp >= 0) check_val($sformatf("latency%0d", r), n, lat_exp);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(negedge CLK);
        check_val("rst_ack", {ACK1, ACK0}, 2'b00);
        check_val("rst_err", {ERR1, ERR0}, 2'b00);
        check_val("rst_rdata0", RDATA0, 32'h0);
        check_val("rst_rdata1", RDATA1, 32'h0);
        check_val("rst_addrbus", ADDRBUS, 32'h0);
        check_val("rst_we", WE, 1'b0);
        check_val("rst_databus_z", DATABUS, zv);
        RESET_N = 1'b1;
        bus_base = bus_cycles;
        @(negedge CLK);

        // Write A5 to LED, then read it back from requester 1.
        run_txn(0, 1'b1, LED_BASE, 32'h0000_00A5, 32'h0, 2, 1'b0, 1'b1);
        REQ0 = 1'b0;
        check_val("led_after_write", led_r, 32'h0000_00A5);
        @(negedge CLK);
        run_txn(1, 1'b0, LED_BASE, 32'h0, 32'h0000_00A5, 2, 1'b0, 1'b1);
        REQ1 = 1'b0;
        repeat (2) @(negedge CLK);

        // Contention: both masters held busy for three transactions each.
        ack_order.delete();
        fork
            begin
                for (int i = 0; i < 3; i++)
                    run_txn(0, 1'b1, LED_BASE, 32'(32'h11 * (i + 1)), 32'h0, -1, 1'b0, 1'b1);
                REQ0 = 1'b0;
            end
            begin
                for (int j = 0; j < 3; j++)
                    run_txn(1, 1'b0, 32'hFFFF_0200, 32'h0, 32'hA5A5_585A, -1, 1'b0, 1'b1);
                REQ1 = 1'b0;
            end
        join
        check_val("contention_acks", ack_order.size(), 6);
        for (int k = 0; k < 6 && k < ack_order.size(); k++)
            check_val($sformatf("grant_order_%0d", k), ack_order[k], k % 2);
        check_val("led_after_contention", led_r, 32'h0000_0033);
        repeat (2) @(negedge CLK);

        // Reset in the middle of a bus phase aborts it.
        ADDR0 = LED_BASE; WE0 = 1'b1; WDATA0 = 32'h0000_003C; REQ0 = 1'b1;
        @(negedge CLK);
        check_val("mid_bus_addr", ADDRBUS, LED_BASE);
        check_val("mid_bus_we", WE, 1'b1);
        #1 RESET_N = 1'b0;
        #1;
        check_val("abort_addrbus", ADDRBUS, 32'h0);
        check_val("abort_we", WE, 1'b0);
        check_val("abort_databus_z", DATABUS, zv);
        REQ0 = 1'b0;
        shadow0 = 32'h0;
        shadow1 = 32'h0;
        repeat (3) begin
            @(negedge CLK);
            check_val("abort_no_ack", {ACK1, ACK0}, 2'b00);
        end
        check_val("abort_rdata1", RDATA1, 32'h0);
        RESET_N = 1'b1;
        bus_base = bus_cycles;
        ack_order.delete();
        @(negedge CLK);
        fork
            begin run_txn(0, 1'b0, LED_BASE, 32'h0, 32'h0000_0033, 2, 1'b0, 1'b1); REQ0 = 1'b0; end
            begin run_txn(1, 1'b0, LED_BASE, 32'h0, 32'h0000_0033, -1, 1'b0, 1'b1); REQ1 = 1'b0; end
        join
        check_val("post_reset_acks", ack_order.size(), 2);
        if (ack_order.size() > 1) begin
            check_val("post_reset_first", ack_order[0], 0);
            check_val("post_reset_second", ack_order[1], 1);
        end
        @(negedge CLK);

        // Access below the IO window.
`ifdef IO_BUS_ARBITER_RANGECHK_EN
        run_txn(0, 1'b0, 32'h0000_1000, 32'h0, 32'h0000_0033, 1, 1'b1, 1'b0);
`else
        run_txn(0, 1'b0, 32'h0000_1000, 32'h0, 32'h5A5A_4A5A, 2, 1'b0, 1'b1);
`endif
        REQ0 = 1'b0;
        repeat (3) @(negedge CLK);
        check_val("queues_drained", q0.size() + q1.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
